// File: rtl/orpsoc_sim_ctrl.sv
// orpsoc_sim_ctrl: Wishbone classic slave with console byte FIFO, sticky exit latch and cycle counter.
// The 64-bit cycle counter is only built when ORPSOC_SIM_CTRL_CYCLE_COUNTER_EN is defined.
module orpsoc_sim_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int BASE_CHECK = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [7:0]  char_o,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic        exit_o,
    output logic [31:0] exit_code_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    localparam logic [1:0] ADDR_CONSOLE  = 2'd0;
    localparam logic [1:0] ADDR_EXIT     = 2'd1;
    localparam logic [1:0] ADDR_CYCLE_LO = 2'd2;
    localparam logic [1:0] ADDR_CYCLE_HI = 2'd3;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_dat;
    logic          r_exit;
    logic [31:0]   r_exit_code;

    logic [1:0]    w_addr;
    logic          w_req;
    logic          w_empty;
    logic          w_full;
    logic [PW-1:0] w_count;
    logic          w_pop;
    logic          w_console_push_req;
    logic          w_accept;
    logic          w_push;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;
    logic [31:0]   w_cyc_lo;
    logic [31:0]   w_cyc_hi;
    logic          w_unused;

    assign w_addr  = wb_adr_i[3:2];
    assign w_req   = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Pointers carry one extra wrap bit: equal index with differing wrap bit means full.
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_pop   = ~w_empty & char_ready_i;

    // A byte push into a full FIFO is held off unless a pop frees the slot in the same cycle.
    assign w_console_push_req = wb_we_i & (w_addr == ADDR_CONSOLE) & wb_sel_i[0];
    assign w_accept = w_req & ~(w_console_push_req & w_full & ~w_pop);
    assign w_push   = w_accept & w_console_push_req;

    always_comb begin
        w_status        = 32'd0;
        w_status[31:16] = 16'(w_count);
        w_status[1]     = w_empty;
        w_status[0]     = w_full;
    end

    always_comb begin
        w_rdata = 32'd0;
        case (w_addr)
            ADDR_CONSOLE:  w_rdata = w_status;
            ADDR_EXIT:     w_rdata = {31'd0, r_exit};
            ADDR_CYCLE_LO: w_rdata = w_cyc_lo;
            ADDR_CYCLE_HI: w_rdata = w_cyc_hi;
            default:       w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dat       <= 32'd0;
            r_exit      <= 1'b0;
            r_exit_code <= 32'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= 32'd0;
            if (w_accept) begin
                if (wb_we_i && w_addr[1]) begin
                    r_err <= 1'b1;
                end else begin
                    r_ack <= 1'b1;
                    if (!wb_we_i) begin
                        r_dat <= w_rdata;
                    end
                end
                if (wb_we_i && (w_addr == ADDR_EXIT) && !r_exit) begin
                    r_exit      <= 1'b1;
                    r_exit_code <= wb_dat_i;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wb_dat_i[7:0];
        end
    end

`ifdef ORPSOC_SIM_CTRL_CYCLE_COUNTER_EN
    logic [63:0] r_cnt;
    logic [31:0] r_hi_shadow;
    logic        w_cyc_lo_rd;

    assign w_cyc_lo_rd = w_accept & ~wb_we_i & (w_addr == ADDR_CYCLE_LO);

    // A low-word read snapshots the high word so the pair reads coherently.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt       <= 64'd0;
            r_hi_shadow <= 32'd0;
        end else begin
            r_cnt <= r_cnt + 64'd1;
            if (w_cyc_lo_rd) begin
                r_hi_shadow <= r_cnt[63:32];
            end
        end
    end

    assign w_cyc_lo = r_cnt[31:0];
    assign w_cyc_hi = r_hi_shadow;
`else
    assign w_cyc_lo = 32'd0;
    assign w_cyc_hi = 32'd0;
`endif

    assign w_unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], (BASE_CHECK != 0)};

    assign wb_ack_o     = r_ack;
    assign wb_err_o     = r_err;
    assign wb_dat_o     = r_dat;
    assign char_o       = r_mem[r_rd_ptr[AW-1:0]];
    assign char_valid_o = ~w_empty;
    assign exit_o       = r_exit;
    assign exit_code_o  = r_exit_code;

endmodule

// File: tb/tb_orpsoc_sim_ctrl.sv
// tb_orpsoc_sim_ctrl: directed and randomized bench for orpsoc_sim_ctrl with a queue-based reference model.
`timescale 1ns/1ps
module tb_orpsoc_sim_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] wb_adr_i = 32'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [3:0]  wb_sel_i = 4'd0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [7:0]  char_o;
    logic        char_valid_o;
    logic        char_ready_i = 1'b0;
    logic        exit_o;
    logic [31:0] exit_code_o;

    always #5 clk = ~clk;

    orpsoc_sim_ctrl #(.FIFO_DEPTH(DEPTH), .BASE_CHECK(0)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .char_o(char_o), .char_valid_o(char_valid_o), .char_ready_i(char_ready_i),
        .exit_o(exit_o), .exit_code_o(exit_code_o)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: bytes in flight, exit latch, cycle count since reset, high-word snapshot.
    logic [7:0]  exp_q[$];
    logic        m_exit = 1'b0;
    logic [31:0] m_code = 32'd0;
    logic [31:0] m_shadow = 32'd0;
    logic [63:0] run_cnt = 64'd0;
    logic [63:0] edge_val = 64'd0;
    int          cur_cnt = 0;
    int          edge_cnt = 0;
    logic [63:0] acc_cyc_val = 64'd0;
    int          acc_fifo_cnt = 0;
    logic        pend_push = 1'b0;
    logic [7:0]  pend_byte = 8'd0;
    logic        pend_exit = 1'b0;
    logic [31:0] pend_code = 32'd0;
    logic        ready_rand = 1'b0;
    logic        ready_val = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] status_of(input int n);
        logic [31:0] s;
        s = 32'd0;
        s[31:16] = 16'(n);
        s[1] = (n == 0);
        s[0] = (n == DEPTH);
        return s;
    endfunction

    // One clock: account for the edge just passed, check outputs, choose ready for the next edge.
    task automatic step();
        @(negedge clk);
        edge_cnt = cur_cnt;
        if (wb_rst_i) begin
            exp_q.delete();
            m_exit = 1'b0;
            m_code = 32'd0;
            m_shadow = 32'd0;
            run_cnt = 64'd0;
            pend_push = 1'b0;
            pend_exit = 1'b0;
        end else begin
            edge_val = run_cnt;
            run_cnt = run_cnt + 64'd1;
            if (wb_ack_o) begin
                if (pend_push) exp_q.push_back(pend_byte);
                if (pend_exit && !m_exit) begin
                    m_exit = 1'b1;
                    m_code = pend_code;
                end
                pend_push = 1'b0;
                pend_exit = 1'b0;
            end
        end
        if (!wb_ack_o) check("dat_idle", wb_dat_o, 0);
        check("char_valid", char_valid_o, exp_q.size() != 0);
        check("exit_o", exit_o, m_exit);
        check("exit_code", exit_code_o, m_code);
        char_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        cur_cnt = exp_q.size();
        if (char_valid_o && char_ready_i && exp_q.size() != 0) begin
            check("char_o", char_o, exp_q.pop_front());
        end
    endtask

    task automatic do_reset(input int n);
        wb_rst_i = 1'b1;
        repeat (n) step();
        wb_rst_i = 1'b0;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int budget,
                           output logic got_ack, output logic got_err, output logic [31:0] rdata);
        got_ack = 1'b0;
        got_err = 1'b0;
        rdata = 32'd0;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        pend_push = we && (adr[3:2] == 2'd0) && sel[0];
        pend_byte = dat[7:0];
        pend_exit = we && (adr[3:2] == 2'd1);
        pend_code = dat;
        for (int i = 0; i < budget; i++) begin
            step();
            if (wb_ack_o || wb_err_o) begin
                got_ack = wb_ack_o;
                got_err = wb_err_o;
                rdata = wb_dat_o;
                acc_fifo_cnt = edge_cnt;
                acc_cyc_val = edge_val;
                break;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i = 1'b0;
        pend_push = 1'b0;
        pend_exit = 1'b0;
        if (!got_ack && !got_err) begin
            check("xfer_timeout", 1, 0);
        end else begin
            step();
            check("resp_one_cycle", {wb_ack_o, wb_err_o}, 2'b00);
        end
    endtask

    // Random operation whose expected outcome comes from the register-map rules and the model.
    task automatic do_op(input int kind);
        logic a, e, we;
        logic [31:0] r, adr, dat, exp_r;
        logic [3:0] sel;
        logic [1:0] off;
        dat = $urandom();
        sel = 4'($urandom_range(0, 15));
        case (kind)
            0, 1, 2, 3: begin off = 2'd0; we = 1'b1; end
            4:          begin off = 2'd1; we = 1'b1; end
            5:          begin off = 2'd0; we = 1'b0; end
            6:          begin off = 2'd1; we = 1'b0; end
            7:          begin off = 2'd2; we = 1'b0; end
            8:          begin off = 2'd3; we = 1'b0; end
            default:    begin off = 2'($urandom_range(2, 3)); we = 1'b1; end
        endcase
        adr = ($urandom() & 32'hFFFF_FFF0) | {28'd0, off, 2'd0} | 32'($urandom_range(0, 3));
        wb_xfer(we, adr, dat, sel, 200, a, e, r);
        check("op_resp", {a, e}, (we && off[1]) ? 2'b01 : 2'b10);
        if (!we) begin
            exp_r = 32'd0;
            case (off)
                2'd0: exp_r = status_of(acc_fifo_cnt);
                2'd1: exp_r = {31'd0, m_exit};
`ifdef ORPSOC_SIM_CTRL_CYCLE_COUNTER_EN
                2'd2: begin exp_r = acc_cyc_val[31:0]; m_shadow = acc_cyc_val[63:32]; end
                2'd3: exp_r = m_shadow;
`endif
                default: exp_r = 32'd0;
            endcase
            check("op_rdata", r, exp_r);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a, e;
        logic [31:0] r;

        do_reset(10);
        check("rst_ack", wb_ack_o, 0);
        check("rst_err", wb_err_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_valid", char_valid_o, 0);
        check("rst_exit", exit_o, 0);
        check("rst_code", exit_code_o, 0);

        // Cycle counter read accepted at cycle 100 after reset release.
        for (int i = 0; i < 200 && run_cnt != 64'd100; i++) step();
        wb_xfer(1'b0, 32'h8, 32'd0, 4'hF, 20, a, e, r);
`ifdef ORPSOC_SIM_CTRL_CYCLE_COUNTER_EN
        check("cyc_lo_100", r, 32'd100);
        force dut.r_cnt = 64'h0000_0000_FFFF_FFFF;
        wb_xfer(1'b0, 32'h8, 32'd0, 4'hF, 20, a, e, r);
        check("cyc_lo_pre", r, 32'hFFFF_FFFF);
        wb_xfer(1'b0, 32'hC, 32'd0, 4'hF, 20, a, e, r);
        check("cyc_hi_pre", r, 32'd0);
        force dut.r_cnt = 64'h1234_5678_9ABC_DEF0;
        wb_xfer(1'b0, 32'h8, 32'd0, 4'hF, 20, a, e, r);
        check("cyc_lo_snap", r, 32'h9ABC_DEF0);
        wb_xfer(1'b0, 32'hC, 32'd0, 4'hF, 20, a, e, r);
        check("cyc_hi_snap", r, 32'h1234_5678);
        release dut.r_cnt;
        do_reset(2);
`else
        check("cyc_lo_off", r, 32'd0);
        check("cyc_lo_off_ack", {a, e}, 2'b10);
        wb_xfer(1'b0, 32'hC, 32'd0, 4'hF, 20, a, e, r);
        check("cyc_hi_off", r, 32'd0);
        check("cyc_hi_off_ack", {a, e}, 2'b10);
`endif

        // Print path.
        ready_val = 1'b1;
        wb_xfer(1'b1, 32'h0, 32'h48, 4'b0001, 20, a, e, r);
        check("print_ack0", a, 1);
        wb_xfer(1'b1, 32'h0, 32'h69, 4'b0001, 20, a, e, r);
        check("print_ack1", a, 1);
        repeat (3) step();
        wb_xfer(1'b0, 32'h0, 32'd0, 4'hF, 20, a, e, r);
        check("print_status", r, 32'h0000_0002);

        // Backpressure: 16 accepted, 17th stalls until one pop.
        ready_val = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_xfer(1'b1, 32'h0, 32'($urandom_range(0, 255)), 4'b0001, 20, a, e, r);
            check("bp_ack", a, 1);
        end
        wb_xfer(1'b0, 32'h0, 32'd0, 4'hF, 20, a, e, r);
        check("bp_status_full", r, 32'h0010_0001);
        wb_adr_i = 32'h3; wb_dat_i = 32'h0000_00A5; wb_sel_i = 4'b0001; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; pend_push = 1'b1; pend_byte = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_stall", wb_ack_o, 0);
        end
        ready_val = 1'b1;
        step();
        check("bp_stall_pop", wb_ack_o, 0);
        ready_val = 1'b0;
        step();
        check("bp_ack17", wb_ack_o, 1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; pend_push = 1'b0;
        step();
        wb_xfer(1'b0, 32'h0, 32'd0, 4'hF, 20, a, e, r);
        check("bp_status_refull", r, 32'h0010_0001);

        // Abandoned full-FIFO write: no push, no ack.
        wb_adr_i = 32'h0; wb_dat_i = 32'h0000_00EE; wb_sel_i = 4'b0001; wb_we_i = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; pend_push = 1'b1; pend_byte = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abandon_stall", wb_ack_o, 0);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; pend_push = 1'b0;
        ready_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abandon_no_ack", wb_ack_o, 0);
        end
        repeat (20) step();
        wb_xfer(1'b0, 32'h0, 32'd0, 4'hF, 20, a, e, r);
        check("abandon_status", r, 32'h0000_0002);

        // Error and no-op writes.
        wb_xfer(1'b1, 32'h8, 32'h1234, 4'hF, 20, a, e, r);
        check("err_lo", {a, e}, 2'b01);
        wb_xfer(1'b1, 32'hC, 32'h1234, 4'hF, 20, a, e, r);
        check("err_hi", {a, e}, 2'b01);
        wb_xfer(1'b1, 32'h0, 32'h0000_0077, 4'b1000, 20, a, e, r);
        check("sel_noop_ack", {a, e}, 2'b10);
        step();
        check("sel_noop_empty", char_valid_o, 0);

        // Exit latch: first write wins.
        wb_xfer(1'b1, 32'h4, 32'h0000_002A, 4'hF, 20, a, e, r);
        check("exit_ack0", a, 1);
        wb_xfer(1'b1, 32'h4, 32'h0000_0005, 4'hF, 20, a, e, r);
        check("exit_ack1", a, 1);
        check("exit_held", exit_o, 1);
        check("exit_code_held", exit_code_o, 32'h0000_002A);
        wb_xfer(1'b0, 32'h4, 32'd0, 4'hF, 20, a, e, r);
        check("exit_read", r, 32'd1);

        // Reset mid-run.
        ready_val = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_xfer(1'b1, 32'h0, 32'($urandom_range(0, 255)), 4'b0001, 20, a, e, r);
        end
        do_reset(1);
        check("mid_rst_valid", char_valid_o, 0);
        check("mid_rst_exit", exit_o, 0);
        wb_xfer(1'b0, 32'h0, 32'd0, 4'hF, 20, a, e, r);
        check("mid_rst_status", r, 32'h0000_0002);

        // Randomized traffic against the model.
        ready_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            do_op($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) step();
        end
        ready_rand = 1'b0;
        ready_val = 1'b1;
        repeat (DEPTH + 4) step();
        wb_xfer(1'b0, 32'h0, 32'd0, 4'hF, 20, a, e, r);
        check("final_status", r, 32'h0000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
